// File: rtl/rf_pkg.sv
// Shared types, defaults and address-legality helper for the multi-port register file.
package rf_pkg;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    localparam int unsigned RF_DATA_W   = 32;
    localparam int unsigned RF_NUM_REGS = 64;

    // An address is usable for a read or a write when it names a real entry and is not
    // the hardwired zero register.
    function automatic logic rf_legal(input int unsigned addr, input logic zero_reg,
                                      input int unsigned num_regs = RF_NUM_REGS);
        return (addr < num_regs) && !(zero_reg && (addr == 0));
    endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Post-reset clear sequencer: walks every entry once, writing zero, then enters READY.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int unsigned NUM_REGS = RF_NUM_REGS,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    // State and counter registers; reset restarts the sweep from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RF_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next-state: one entry per cycle, leave CLEAR once the last entry is written.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        if (state_q == RF_CLEAR) begin
            clr_we = !rst;
            if (clr_cnt_q == LastAddr) begin
                state_d   = RF_READY;
                clr_cnt_d = '0;
            end else begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
        end
    end

    assign clr_addr = clr_cnt_q;
    // Reset itself counts as busy so a write in the reset cycle is dropped.
    assign busy     = rst || (state_q == RF_CLEAR);

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two prioritised write ports, NUM_RD combinational read ports,
// optional zero register and write-to-read bypass. Storage has no reset net; it is zeroed
// by the clear sequencer after reset.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned NUM_REGS = RF_NUM_REGS,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [1:0]               wr_en,
    input  logic [2*ADDR_W-1:0]      wr_addr,
    input  logic [2*DATA_W-1:0]      wr_data,
    output logic                     busy
);

    localparam logic ZeroEn = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem [NUM_REGS];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] wa [2];
    logic [DATA_W-1:0] wd [2];
    logic [1:0]        wr_ok;

    rf_clear_seq #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Unpack write ports and qualify each: ignored while busy or when the address is illegal.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            wa[p]    = wr_addr[p*ADDR_W +: ADDR_W];
            wd[p]    = wr_data[p*DATA_W +: DATA_W];
            wr_ok[p] = wr_en[p] && !busy && rf_legal(32'(wa[p]), ZeroEn, NUM_REGS);
        end
    end

    // Array update: clear sweep, else port 0 then port 1 so port 1 wins a collision.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wr_ok[0]) mem[wa[0]] <= wd[0];
            if (wr_ok[1]) mem[wa[1]] <= wd[1];
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        // Read lane: zero while busy or for illegal addresses, optional bypass with port 1 last.
        always_comb begin
            rv = '0;
            if (!busy && rf_legal(32'(ra), ZeroEn, NUM_REGS)) begin
                rv = mem[ra];
                if (BYPASS != 0) begin
                    if (wr_ok[0] && (wa[0] == ra)) rv = wd[0];
                    if (wr_ok[1] && (wa[1] == ra)) rv = wd[1];
                end
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = rv;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (64 entries with zero reg and bypass; 40 entries with
// neither) share one stimulus stream and are checked against an array model every cycle.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2*AW-1:0] rd_addr = '0;
    logic [1:0]      wr_en = '0;
    logic [2*AW-1:0] wr_addr = '0;
    logic [2*DW-1:0] wr_data = '0;
    logic [2*DW-1:0] rd_data_a, rd_data_b;
    logic            busy_a, busy_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_file_mp #(
        .DATA_W   (32),
        .NUM_REGS (64),
        .NUM_RD   (2),
        .ZERO_REG (1),
        .BYPASS   (1)
    ) dut_a (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (rd_addr),
        .rd_data (rd_data_a),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy_a)
    );

    reg_file_mp #(
        .DATA_W   (32),
        .NUM_REGS (40),
        .NUM_RD   (2),
        .ZERO_REG (0),
        .BYPASS   (0)
    ) dut_b (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (rd_addr),
        .rd_data (rd_data_b),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy_b)
    );

    // Model: index 0 mirrors dut_a's configuration, index 1 mirrors dut_b's.
    logic [31:0] m [2][64];
    int          clr_left [2];
    bit          model_ok = 1'b0;

    function automatic int nregs(input int d);
        return (d == 0) ? 64 : 40;
    endfunction

    function automatic bit legal(input int d, input int a);
        return (a < nregs(d)) && !((d == 0) && (a == 0));
    endfunction

    function automatic int waddr(input int p);
        return int'(wr_addr[p*AW +: AW]);
    endfunction

    function automatic logic [31:0] wdata(input int p);
        return wr_data[p*DW +: DW];
    endfunction

    function automatic bit exp_busy(input int d);
        return rst || (clr_left[d] > 0);
    endfunction

    function automatic logic [31:0] exp_rd(input int d, input int a);
        if (exp_busy(d) || !legal(d, a)) return 32'd0;
        if (d == 0) begin
            if (wr_en[1] && legal(d, waddr(1)) && waddr(1) == a) return wdata(1);
            if (wr_en[0] && legal(d, waddr(0)) && waddr(0) == a) return wdata(0);
        end
        return m[d][a];
    endfunction

    // Model update at each edge from the (stable) inputs of the cycle just ended.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                clr_left[d] = nregs(d);
                for (int i = 0; i < 64; i++) m[d][i] = 32'd0;
            end else if (clr_left[d] > 0) begin
                clr_left[d] = clr_left[d] - 1;
            end else begin
                for (int p = 0; p < 2; p++)
                    if (wr_en[p] && legal(d, waddr(p))) m[d][waddr(p)] = wdata(p);
            end
        end
        if (rst) model_ok = 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            check("busy_a", 64'(busy_a), 64'(exp_busy(0)));
            check("busy_b", 64'(busy_b), 64'(exp_busy(1)));
            for (int k = 0; k < 2; k++) begin
                check($sformatf("rd_a[%0d]", k), 64'(rd_data_a[k*DW +: DW]),
                      64'(exp_rd(0, int'(rd_addr[k*AW +: AW]))));
                check($sformatf("rd_b[%0d]", k), 64'(rd_data_b[k*DW +: DW]),
                      64'(exp_rd(1, int'(rd_addr[k*AW +: AW]))));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit e0, input int a0, input logic [31:0] d0,
                         input bit e1, input int a1, input logic [31:0] d1,
                         input int r0, input int r1);
        wr_en   = {e1, e0};
        wr_addr = {AW'(a1), AW'(a0)};
        wr_data = {d1, d0};
        rd_addr = {AW'(r1), AW'(r0)};
    endtask

    task automatic idle(input int r0, input int r1);
        drive(1'b0, 0, 32'd0, 1'b0, 0, 32'd0, r0, r1);
    endtask

    // Counts edges until dut_a leaves busy (bounded), and how many of them dut_b was busy.
    task automatic wait_ready(output int ca, output int cb);
        ca = 0;
        cb = 0;
        while (busy_a && ca < 200) begin
            if (busy_b) cb++;
            step();
            ca++;
        end
    endtask

    int cnt_a, cnt_b;

    initial begin
        idle(0, 0);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        wait_ready(cnt_a, cnt_b);

        // Preload every entry with a marker so the next clear has something to erase.
        for (int i = 1; i < 64; i += 2) begin
            drive(1'b1, i, 32'hDEADBEEF, 1'b1, i + 1, 32'hDEADBEEF, 0, 0);
            step();
        end
        idle(7, 40);
        @(negedge clk);
        check("preload r7", 64'(rd_data_a[31:0]), 64'h0000_0000_DEAD_BEEF);

        // Reset for three cycles, then time the clear on both instances.
        step();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        wait_ready(cnt_a, cnt_b);
        check("clear edges a", 64'(cnt_a), 64'd64);
        check("clear edges b", 64'(cnt_b), 64'd40);
        for (int i = 0; i < 64; i += 2) begin
            idle(i, i + 1);
            @(negedge clk);
            if (i == 0) check("r1 cleared", 64'(rd_data_a[63:32]), 64'd0);
            if (i == 62) check("r63 cleared", 64'(rd_data_a[63:32]), 64'd0);
            step();
        end

        // Dual write to distinct addresses.
        drive(1'b1, 1, 32'd16, 1'b1, 2, 32'd22, 0, 0);
        step();
        idle(1, 2);
        @(negedge clk);
        check("dual write a", rd_data_a, {32'd22, 32'd16});
        check("dual write b", rd_data_b, {32'd22, 32'd16});
        step();

        // Collision on r5 and a write to r0.
        drive(1'b1, 5, 32'd10, 1'b1, 5, 32'd9, 0, 0);
        step();
        drive(1'b1, 0, 32'd7, 1'b0, 0, 32'd0, 5, 0);
        @(negedge clk);
        check("collision r5", 64'(rd_data_a[31:0]), 64'd9);
        step();
        idle(0, 5);
        @(negedge clk);
        check("zero reg a", 64'(rd_data_a[31:0]), 64'd0);
        check("r0 write b", 64'(rd_data_b[31:0]), 64'd7);
        step();

        // Bypass on r3 with an old value of 11.
        drive(1'b1, 3, 32'd11, 1'b0, 0, 32'd0, 0, 0);
        step();
        drive(1'b1, 3, 32'd42, 1'b0, 0, 32'd0, 3, 3);
        @(negedge clk);
        check("bypass a", 64'(rd_data_a[31:0]), 64'd42);
        check("no bypass b", 64'(rd_data_b[31:0]), 64'd11);
        step();
        idle(3, 3);
        @(negedge clk);
        check("after write b", 64'(rd_data_b[63:32]), 64'd42);
        step();
        // Both ports to r6 while reading it: bypass must follow port 1.
        drive(1'b1, 6, 32'd13, 1'b1, 6, 32'd42, 6, 6);
        @(negedge clk);
        check("bypass prio a", 64'(rd_data_a[63:32]), 64'd42);
        step();

        // Out-of-range for dut_b, in range for dut_a.
        drive(1'b1, 45, 32'd5, 1'b0, 0, 32'd0, 45, 45);
        step();
        idle(45, 39);
        @(negedge clk);
        check("oob read b", 64'(rd_data_b[31:0]), 64'd0);
        check("r45 a", 64'(rd_data_a[31:0]), 64'd5);
        step();
        for (int i = 0; i < 64; i += 2) begin
            idle(i, i + 1);
            step();
        end

        // Reset at clear cycle 20, with a write attempted during the restarted clear.
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (20) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cnt_a = 0;
        while (busy_a && cnt_a < 200) begin
            if (cnt_a < 5) drive(1'b0, 0, 32'd0, 1'b1, 9, 32'd77, 9, 9);
            else idle(9, 9);
            step();
            cnt_a++;
        end
        check("restart edges a", 64'(cnt_a), 64'd64);
        idle(9, 9);
        @(negedge clk);
        check("busy write dropped", 64'(rd_data_a[31:0]), 64'd0);
        step();
        drive(1'b1, 9, 32'd3, 1'b0, 0, 32'd0, 9, 9);
        step();
        idle(9, 9);
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
